// File: rtl/comparator_self_test_pkg.sv
// Shared types and constants for the comparator self-test sequencer:
// FSM states, status codes, the stimulus vector table and the pass criterion.
package comparator_self_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BIAS,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_REPORT,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_PASS = 2'b11;
  localparam logic [1:0] ST_FAIL = 2'b10;

  // Only vectors 1 and 2 have an unambiguous ideal answer; 0 and 3 are vp==vn.
  localparam logic [3:0] PASS_MASK   = 4'b0110;
  localparam logic [3:0] PASS_EXPECT = 4'b0100;

  // Returns {vp, vn} for a vector index.
  function automatic logic [1:0] vec_of(input logic [1:0] idx);
    logic [1:0] v;
    v = 2'b00;
    case (idx)
      2'd0: v = 2'b00;
      2'd1: v = 2'b01;
      2'd2: v = 2'b10;
      2'd3: v = 2'b11;
      default: v = 2'b00;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/comp_sync.sv
// Two-flop synchronizer for an asynchronous analog-derived level, with
// synchronous active-high reset to 0.
module comp_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/comparator_self_test.sv
// Stimulus/check sequencer for the user-area analog comparator: sweeps four
// (vp,vn) vectors, majority-votes the synchronized output, reports pass/fail.
module comparator_self_test
  import comparator_self_test_pkg::*;
#(
  parameter int unsigned BIAS_CYCLES   = 16,
  parameter int unsigned SETTLE_CYCLES = 20,
  parameter int unsigned SAMPLES       = 3
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start,
  input  logic       vout,
  output logic       vp,
  output logic       vn,
  output logic       bias_en,
  output logic       busy,
  output logic [1:0] status,
  output logic [3:0] checkbits,
  output logic       done
);

  localparam logic [7:0] BIAS_LAST   = 8'(BIAS_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLES - 1);
  localparam logic [3:0] HALF        = 4'(SAMPLES / 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] cb_q, cb_d;
  logic [1:0] status_q, status_d;
  logic       vp_q, vp_d;
  logic       vn_q, vn_d;
  logic       bias_q, bias_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       vout_s;
  logic [3:0] ones_sum;

  comp_sync u_sync (
    .clk (wb_clk_i),
    .rst (wb_rst_i),
    .d_i (vout),
    .q_o (vout_s)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    ones_d   = ones_q;
    cb_d     = cb_q;
    status_d = status_q;
    vp_d     = vp_q;
    vn_d     = vn_q;
    done_d   = 1'b0;
    ones_sum = ones_q + {3'b000, vout_s};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d  = S_BIAS;
          cnt_d    = '0;
          idx_d    = '0;
          cb_d     = '0;
          vp_d     = 1'b0;
          vn_d     = 1'b0;
          status_d = ST_RUN;
        end
      end
      S_BIAS: begin
        if (cnt_q == BIAS_LAST) begin
          cnt_d   = '0;
          state_d = S_DRIVE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRIVE: begin
        {vp_d, vn_d} = vec_of(idx_q);
        cnt_d        = '0;
        state_d      = S_SETTLE;
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          ones_d  = '0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        ones_d = ones_sum;
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d       = '0;
          cb_d[idx_q] = (ones_sum > HALF);
          if (idx_q == 2'd3) begin
            state_d = S_REPORT;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_DRIVE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_REPORT: begin
        status_d = ((cb_q & PASS_MASK) == PASS_EXPECT) ? ST_PASS : ST_FAIL;
        done_d   = 1'b1;
        vp_d     = 1'b0;
        vn_d     = 1'b0;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Derived from the next state so both are registered yet align with it.
    busy_d = (state_d inside {S_BIAS, S_DRIVE, S_SETTLE, S_SAMPLE, S_REPORT});
    bias_d = busy_d;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      ones_q   <= '0;
      cb_q     <= '0;
      status_q <= ST_IDLE;
      vp_q     <= 1'b0;
      vn_q     <= 1'b0;
      bias_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      ones_q   <= ones_d;
      cb_q     <= cb_d;
      status_q <= status_d;
      vp_q     <= vp_d;
      vn_q     <= vn_d;
      bias_q   <= bias_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign vp        = vp_q;
  assign vn        = vn_q;
  assign bias_en   = bias_q;
  assign busy      = busy_q;
  assign status    = status_q;
  assign checkbits = cb_q;
  assign done      = done_q;

endmodule

// File: tb/tb_comparator_self_test.sv
// Directed bench for comparator_self_test with a behavioural comparator model
// (ideal, stuck-at, inverted) and injectable low glitches on vout.
module tb_comparator_self_test;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       vout;
  logic       vp, vn, bias_en, busy, done;
  logic [1:0] status;
  logic [3:0] checkbits;

  int   model;   // 0 ideal, 1 stuck-1, 2 stuck-0, 3 inverted
  logic noise;
  logic mdl_out;
  int   checks = 0;
  int   errors = 0;

  comparator_self_test #(
    .BIAS_CYCLES  (16),
    .SETTLE_CYCLES(20),
    .SAMPLES      (3)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .start    (start),
    .vout     (vout),
    .vp       (vp),
    .vn       (vn),
    .bias_en  (bias_en),
    .busy     (busy),
    .status   (status),
    .checkbits(checkbits),
    .done     (done)
  );

  initial forever #5 clk = ~clk;

  always_comb begin
    mdl_out = 1'b0;
    case (model)
      0: mdl_out = vp & ~vn;
      1: mdl_out = 1'b1;
      2: mdl_out = 1'b0;
      3: mdl_out = vn & ~vp;
      default: mdl_out = 1'b0;
    endcase
  end

  assign vout = noise ? 1'b0 : mdl_out;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the negedge just after the edge that samples start.
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_bias"}, {7'd0, bias_en}, 8'd0);
    chk({tag, "_vpvn"}, {6'd0, vp, vn}, 8'd0);
    chk({tag, "_status"}, {6'd0, status}, 8'd0);
    chk({tag, "_cb"}, {4'd0, checkbits}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
  endtask

  // Full sweep; done expected 113 cycles after the start edge.
  task automatic sweep(input string tag, input logic [3:0] exp_cb, input logic [1:0] exp_st,
                       input int lows, input bit extra_starts);
    int   done_at;
    logic busy_pre, busy_at_done;
    done_at      = -1;
    busy_pre     = 1'b0;
    busy_at_done = 1'b1;
    pulse_start();
    chk({tag, "_run_status"}, {6'd0, status}, 8'h01);
    chk({tag, "_run_busy"}, {6'd0, busy, bias_en}, 8'h03);
    chk({tag, "_run_cb"}, {4'd0, checkbits}, 8'h00);
    chk({tag, "_run_vpvn"}, {6'd0, vp, vn}, 8'h00);
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (lows > 0 && k == 83) noise = 1'b1;
      if (k == 83 + lows) noise = 1'b0;
      if (extra_starts && (k == 30 || k == 100)) start = 1'b1;
      if (extra_starts && (k == 31 || k == 101)) start = 1'b0;
      if (k == 112) busy_pre = busy;
      if (done === 1'b1) begin
        done_at      = k;
        busy_at_done = busy;
        break;
      end
    end
    noise = 1'b0;
    start = 1'b0;
    chk({tag, "_done_at"}, 8'(done_at), 8'd113);
    chk({tag, "_busy_pre"}, {7'd0, busy_pre}, 8'd1);
    chk({tag, "_busy_at_done"}, {7'd0, busy_at_done}, 8'd0);
    chk({tag, "_cb"}, {4'd0, checkbits}, {4'd0, exp_cb});
    chk({tag, "_status"}, {6'd0, status}, {6'd0, exp_st});
    @(negedge clk);
    chk({tag, "_done_once"}, {7'd0, done}, 8'd0);
    chk({tag, "_hold"}, {2'd0, status, checkbits}, {2'd0, exp_st, exp_cb});
    chk({tag, "_after_io"}, {5'd0, bias_en, vp, vn}, 8'd0);
  endtask

  initial begin
    int dones;
    rst   = 1'b1;
    start = 1'b0;
    noise = 1'b0;
    model = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");

    start = 1'b1;
    @(negedge clk);
    check_idle_outputs("rst_vs_start");
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);

    model = 0; sweep("ideal",    4'b0100, 2'b11, 0, 1'b0);
    model = 1; sweep("stuck1",   4'b1111, 2'b10, 0, 1'b0);
    model = 2; sweep("stuck0",   4'b0000, 2'b10, 0, 1'b0);
    model = 3; sweep("inverted", 4'b0010, 2'b10, 0, 1'b0);
    model = 0; sweep("noise1",   4'b0100, 2'b11, 1, 1'b0);
    model = 0; sweep("noise2",   4'b0000, 2'b10, 2, 1'b0);

    // Abort during vector 2 SETTLE (cycles 65..84 after the start edge).
    model = 0;
    pulse_start();
    repeat (70) @(negedge clk);
    chk("abort_pre_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("abort");
    dones = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done !== 1'b0) dones++;
    end
    chk("abort_no_done", 8'(dones), 8'd0);
    chk("abort_idle_status", {6'd0, status, busy}, 8'd0);

    sweep("post_abort", 4'b0100, 2'b11, 0, 1'b0);
    sweep("extra_start", 4'b0100, 2'b11, 0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
